// File: rtl/as_top_mem_pkg.sv
// as_pack: shared widths, encodings and TAP state type for the as_top_mem slice
package as_pack;
  localparam int IMEM_ADDR_W = 10;
  localparam int INSTR_W = 32;
  localparam int IM_SCAN_LEN = IMEM_ADDR_W + INSTR_W + 1;
  localparam int NR_GPIOS = 32;
  localparam int GPIO_ADDR_W = 8;
  localparam int IR_W = 8;
  localparam logic [7:0] IMDR_OP = 8'h80;
  localparam logic [47:0] GPIO_BASE = 48'h1;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR: return tms ? TLR : RTI;
      RTI: return tms ? SEL_DR : RTI;
      SEL_DR: return tms ? SEL_IR : CAP_DR;
      CAP_DR: return tms ? EX1_DR : SH_DR;
      SH_DR: return tms ? EX1_DR : SH_DR;
      EX1_DR: return tms ? UPD_DR : PAU_DR;
      PAU_DR: return tms ? EX2_DR : PAU_DR;
      EX2_DR: return tms ? UPD_DR : SH_DR;
      UPD_DR: return tms ? SEL_DR : RTI;
      SEL_IR: return tms ? TLR : CAP_IR;
      CAP_IR: return tms ? EX1_IR : SH_IR;
      SH_IR: return tms ? EX1_IR : SH_IR;
      EX1_IR: return tms ? UPD_IR : PAU_IR;
      PAU_IR: return tms ? EX2_IR : PAU_IR;
      EX2_IR: return tms ? UPD_IR : SH_IR;
      UPD_IR: return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction
endpackage

// File: rtl/as_top_mem_jtag_tap.sv
// as_jtag_tap: oversampled JTAG TAP with IR, IMDR scan register and bypass
module as_jtag_tap
  import as_pack::*;
#(
  parameter int AW = IMEM_ADDR_W,
  parameter int DW = INSTR_W,
  parameter int IRW = IR_W
) (
  input  logic clk,
  input  logic trst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  input  logic [DW-1:0] rdata,
  output logic tdo,
  output logic wr,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  localparam int L = AW + DW + 1;
  tap_state_t state;
  logic [1:0] sync;
  logic tck_q, byp, rise, fall, imdr, ir_sel;
  logic [IRW-1:0] ir, irs;
  logic [L-1:0] dr;
  assign rise = sync[1] & ~tck_q;
  assign fall = ~sync[1] & tck_q;
  assign imdr = ir == IRW'(IMDR_OP);
  assign ir_sel = state inside {CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR};
  assign addr = dr[L-1 -: AW];
  assign data = dr[DW:1];
  // actions belong to the state being left on each tck rise
  always_ff @(posedge clk) begin
    if (trst) begin
      sync <= '0;
      tck_q <= 1'b0;
      state <= TLR;
      ir <= '0;
      irs <= '0;
      dr <= '0;
      byp <= 1'b0;
      tdo <= 1'b0;
      wr <= 1'b0;
    end else begin
      sync <= {sync[0], tck};
      tck_q <= sync[1];
      wr <= rise && state == UPD_DR && imdr && dr[0];
      if (state == TLR) ir <= '0;
      if (rise) begin
        state <= tap_next(state, tms);
        if (state == CAP_IR) irs <= IRW'(1);
        if (state == SH_IR) irs <= {irs[IRW-2:0], tdi};
        if (state == UPD_IR) ir <= irs;
        if (state == CAP_DR) begin
          if (imdr) dr <= {addr, rdata, 1'b0};
          else byp <= 1'b0;
        end
        if (state == SH_DR) begin
          if (imdr) dr <= {dr[L-2:0], tdi};
          else byp <= tdi;
        end
      end
      if (fall) tdo <= ir_sel ? irs[IRW-1] : imdr ? dr[L-1] : byp;
    end
  end
endmodule

// File: rtl/as_top_mem.sv
// as_top_mem: single-cycle RV64I-subset core with JTAG-loaded instruction memory and GPIO stores
module as_top_mem #(
  parameter int IMEM_ADDR_W = as_pack::IMEM_ADDR_W,
  parameter int INSTR_W = as_pack::INSTR_W,
  parameter int NR_GPIOS = as_pack::NR_GPIOS,
  parameter int GPIO_ADDR_W = as_pack::GPIO_ADDR_W,
  parameter int IR_W = as_pack::IR_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tck_i,
  input  logic trst_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic [NR_GPIOS-1:0] gpio_o,
  output logic [GPIO_ADDR_W-1:0] gpioAddr_o,
  output logic cs_o
);
  import as_pack::*;
  logic [INSTR_W-1:0] imem [2**(IMEM_ADDR_W-2)];
  logic [63:0] regs [32];
  logic [63:0] pc, r1, r2, imm_i, imm_s, imm_b, imm_j, imm_u, wb, st_addr, mask, next_pc;
  logic [INSTR_W-1:0] instr, tap_data;
  logic [IMEM_ADDR_W-1:0] tap_addr;
  logic [6:0] opc;
  logic [4:0] rd;
  logic [2:0] f3;
  logic tap_wr, is_lui, is_addi, is_jal, taken, wb_en, gpio_st, unused;
  as_jtag_tap #(.AW(IMEM_ADDR_W), .DW(INSTR_W), .IRW(IR_W)) u_tap (
    .clk(clk_i), .trst(trst_i), .tck(tck_i), .tms(tms_i), .tdi(tdi_i),
    .rdata(imem[tap_addr[IMEM_ADDR_W-1:2]]), .tdo(tdo_o), .wr(tap_wr),
    .addr(tap_addr), .data(tap_data)
  );
  assign instr = imem[pc[IMEM_ADDR_W-1:2]];
  assign unused = ^{st_addr, tap_addr};
  always_comb begin
    opc = instr[6:0];
    rd = instr[11:7];
    f3 = instr[14:12];
    r1 = regs[instr[19:15]];
    r2 = regs[instr[24:20]];
    imm_i = {{52{instr[31]}}, instr[31:20]};
    imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    is_lui = opc == OP_LUI;
    is_addi = opc == OP_IMM && f3 == 3'd0;
    is_jal = opc == OP_JAL;
    taken = is_jal || (opc == OP_BRANCH && ((f3 == 3'd0 && r1 == r2) || (f3 == 3'd1 && r1 != r2)));
    next_pc = pc + (taken ? (is_jal ? imm_j : imm_b) : 64'd4);
    wb_en = rd != 5'd0 && (is_lui || is_addi || is_jal);
    wb = is_lui ? imm_u : is_addi ? r1 + imm_i : pc + 64'd4;
    st_addr = r1 + imm_s;
    gpio_st = opc == OP_STORE && !f3[2] && st_addr[63:16] == GPIO_BASE;
    mask = f3[1:0] == 2'd0 ? 64'hFF : f3[1:0] == 2'd1 ? 64'hFFFF : f3[1:0] == 2'd2 ? 64'hFFFF_FFFF : '1;
  end
  always_ff @(posedge clk_i) begin
    if (tap_wr) imem[tap_addr[IMEM_ADDR_W-1:2]] <= tap_data;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      cs_o <= 1'b0;
      gpio_o <= '0;
      gpioAddr_o <= '0;
    end else begin
      pc <= next_pc;
      if (wb_en) regs[rd] <= wb;
      cs_o <= gpio_st;
      if (gpio_st) begin
        gpioAddr_o <= st_addr[GPIO_ADDR_W-1:0];
        gpio_o <= NR_GPIOS'(r2 & mask);
      end
    end
  end
endmodule

// File: tb/tb_as_top_mem.sv
// tb_as_top_mem: JTAG-driven loading of programs into as_top_mem with GPIO-store and TAP checks
module tb_as_top_mem;
  logic clk_i = 0, rst_i = 1, tck_i = 0, trst_i = 1, tms_i = 1, tdi_i = 0;
  logic tdo_o, cs_o;
  logic [31:0] gpio_o;
  logic [7:0] gaddr;
  int checks = 0, errors = 0;
  logic [31:0] mem_m [256];
  logic [42:0] dr_m = '0;
  always #5 clk_i = ~clk_i;
  as_top_mem dut (
    .clk_i(clk_i), .rst_i(rst_i), .tck_i(tck_i), .trst_i(trst_i), .tms_i(tms_i),
    .tdi_i(tdi_i), .tdo_o(tdo_o), .gpio_o(gpio_o), .gpioAddr_o(gaddr), .cs_o(cs_o)
  );
  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'd0, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  task automatic tclk(input logic tms, input logic tdi, output logic tdo_s);
    tms_i = tms;
    tdi_i = tdi;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    tdo_s = tdo_o;
    tck_i = 1;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    tck_i = 0;
  endtask
  task automatic tap_reset();
    logic b;
    repeat (5) tclk(1'b1, 1'b0, b);
    tclk(1'b0, 1'b0, b);
  endtask
  task automatic shift_ir(input logic [7:0] v, output logic [7:0] o);
    logic b;
    tclk(1'b1, 1'b0, b); tclk(1'b1, 1'b0, b); tclk(1'b0, 1'b0, b); tclk(1'b0, 1'b0, b);
    for (int i = 7; i >= 0; i--) begin tclk(i == 0, v[i], b); o[i] = b; end
    tclk(1'b1, 1'b0, b); tclk(1'b0, 1'b0, b);
  endtask
  task automatic scan_dr(input logic [42:0] din, output logic [42:0] dout);
    logic b;
    tclk(1'b1, 1'b0, b); tclk(1'b0, 1'b0, b); tclk(1'b0, 1'b0, b);
    for (int i = 42; i >= 0; i--) begin tclk(i == 0, din[i], b); dout[i] = b; end
    tclk(1'b1, 1'b0, b); tclk(1'b0, 1'b0, b);
  endtask
  task automatic imdr(input logic [9:0] a, input logic [31:0] d, input logic we, output logic [42:0] got, output logic [42:0] exp);
    exp = {dr_m[42:33], mem_m[dr_m[42:35]], 1'b0};
    scan_dr({a, d, we}, got);
    dr_m = {a, d, we};
    if (we) mem_m[a[9:2]] = d;
  endtask
  task automatic load(input logic [31:0] prog [$]);
    logic [42:0] g, e;
    foreach (prog[i]) imdr(10'(i * 4), prog[i], 1'b1, g, e);
  endtask
  task automatic run(output int n, output logic [31:0] g, output logic [7:0] a);
    n = 0;
    g = 'x;
    a = 'x;
    @(negedge clk_i);
    rst_i = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (cs_o) begin n++; g = gpio_o; a = gaddr; end
    end
    rst_i = 1;
    repeat (2) @(negedge clk_i);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++; if (cs_o !== 1'b0) begin errors++; $display("FAIL reset_cs got %h exp 0", cs_o); end
    checks++; if (gpio_o !== 32'h0) begin errors++; $display("FAIL reset_gpio got %h exp 0", gpio_o); end
    checks++; if (gaddr !== 8'h0) begin errors++; $display("FAIL reset_gaddr got %h exp 0", gaddr); end
    checks++; if (tdo_o !== 1'b0) begin errors++; $display("FAIL reset_tdo got %h exp 0", tdo_o); end
    checks++; if (dut.u_tap.ir !== 8'h00) begin errors++; $display("FAIL reset_ir got %h exp 00", dut.u_tap.ir); end
    trst_i = 0;
  endtask
  task automatic test_ir();
    logic [7:0] o;
    tap_reset();
    shift_ir(8'h80, o);
    checks++; if (o !== 8'h01) begin errors++; $display("FAIL ir_capture got %h exp 01", o); end
    checks++; if (dut.u_tap.ir !== 8'h80) begin errors++; $display("FAIL ir_update got %h exp 80", dut.u_tap.ir); end
  endtask
  task automatic test_imdr_rw();
    logic [42:0] g, e;
    for (int i = 0; i < 5; i++) begin
      imdr(10'(i * 4), 32'h0, 1'b1, g, e);
      if (!$isunknown(e)) begin
        checks++; if (g !== e) begin errors++; $display("FAIL imdr_clear got %h exp %h", g, e); end
      end
    end
    for (int i = 0; i < 6; i++) begin
      imdr({8'($urandom_range(65, 255)), 2'b00}, $urandom, 1'b1, g, e);
      if (!$isunknown(e)) begin
        checks++; if (g !== e) begin errors++; $display("FAIL imdr_rand got %h exp %h", g, e); end
      end
    end
  endtask
  task automatic test_we0();
    logic [42:0] g, e;
    logic [31:0] d = $urandom;
    imdr(10'h100, d, 1'b1, g, e);
    imdr(10'h100, ~d, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL we0_first got %h exp %h", g, e); end
    imdr(10'h100, 32'h0, 1'b0, g, e);
    checks++; if (g !== {10'h100, d, 1'b0}) begin errors++; $display("FAIL we0_unchanged got %h exp %h", g, {10'h100, d, 1'b0}); end
  endtask
  task automatic test_program();
    logic [31:0] p [$];
    int n;
    logic [31:0] g;
    logic [7:0] a;
    p = '{32'h00010137, 32'h01D00513, 32'h00A10223, 32'h0000006F};
    load(p);
    run(n, g, a);
    checks++; if (n !== 1) begin errors++; $display("FAIL prog_cs_count got %0d exp 1", n); end
    checks++; if (a !== 8'h04) begin errors++; $display("FAIL prog_gaddr got %h exp 04", a); end
    checks++; if (g !== 32'd29) begin errors++; $display("FAIL prog_gpio got %h exp %h", g, 32'd29); end
  endtask
  task automatic test_branch_nop();
    logic [31:0] p [$];
    int n;
    logic [31:0] g;
    logic [7:0] a;
    p = '{enc_addi(5'd10, 5'd0, 12'd7), enc_b(3'd1, 5'd0, 5'd0, 13'd8), enc_addi(5'd10, 5'd0, 12'd5),
          32'hFFFF_FFFF, enc_u(5'd2, 20'h10), enc_s(3'd2, 5'd2, 5'd10, 12'd8), enc_j(5'd0, 21'd0)};
    load(p);
    run(n, g, a);
    checks++; if (n !== 1) begin errors++; $display("FAIL bnop_cs_count got %0d exp 1", n); end
    checks++; if (a !== 8'h08) begin errors++; $display("FAIL bnop_gaddr got %h exp 08", a); end
    checks++; if (g !== 32'd5) begin errors++; $display("FAIL bnop_gpio got %h exp 5", g); end
  endtask
  task automatic test_jal_beq();
    logic [31:0] p [$];
    int n;
    logic [31:0] g;
    logic [7:0] a;
    p = '{enc_j(5'd1, 21'd8), enc_addi(5'd1, 5'd0, 12'd99), enc_b(3'd0, 5'd0, 5'd0, 13'd8), enc_addi(5'd1, 5'd0, 12'd77),
          enc_u(5'd2, 20'h10), enc_s(3'd3, 5'd2, 5'd1, 12'h20), enc_j(5'd0, 21'd0)};
    load(p);
    run(n, g, a);
    checks++; if (n !== 1) begin errors++; $display("FAIL jal_cs_count got %0d exp 1", n); end
    checks++; if (a !== 8'h20) begin errors++; $display("FAIL jal_gaddr got %h exp 20", a); end
    checks++; if (g !== 32'd4) begin errors++; $display("FAIL jal_gpio got %h exp 4", g); end
  endtask
  task automatic test_random_store();
    logic [31:0] p [$];
    int n;
    logic [31:0] g;
    logic [7:0] a;
    for (int t = 0; t < 4; t++) begin
      logic [11:0] imm = 12'($urandom);
      logic [7:0] off = 8'($urandom);
      logic [2:0] f3 = 3'($urandom_range(0, 3));
      logic [63:0] v = {{52{imm[11]}}, imm};
      logic [63:0] m = (f3 == 3'd3) ? '1 : (64'd1 << (8 << f3)) - 64'd1;
      logic [63:0] ev = v & m;
      p = '{enc_u(5'd2, 20'h10), enc_addi(5'd10, 5'd0, imm), enc_s(f3, 5'd2, 5'd10, {4'h0, off}), enc_j(5'd0, 21'd0)};
      load(p);
      run(n, g, a);
      checks++; if (n !== 1) begin errors++; $display("FAIL rnd_cs_count got %0d exp 1", n); end
      checks++; if (a !== off) begin errors++; $display("FAIL rnd_gaddr got %h exp %h", a, off); end
      checks++; if (g !== ev[31:0]) begin errors++; $display("FAIL rnd_gpio got %h exp %h (f3 %0d)", g, ev[31:0], f3); end
    end
  endtask
  task automatic test_non_gpio();
    logic [31:0] p [$];
    int n;
    logic [31:0] g;
    logic [7:0] a;
    p = '{enc_u(5'd2, 20'h20), enc_addi(5'd10, 5'd0, 12'd3), enc_s(3'd2, 5'd2, 5'd10, 12'd0), enc_j(5'd0, 21'd0)};
    load(p);
    run(n, g, a);
    checks++; if (n !== 0) begin errors++; $display("FAIL nongpio_hi got %0d exp 0", n); end
    p = '{enc_u(5'd2, 20'h10), enc_addi(5'd2, 5'd2, 12'hFFF), enc_s(3'd0, 5'd2, 5'd0, 12'd0), enc_j(5'd0, 21'd0)};
    load(p);
    run(n, g, a);
    checks++; if (n !== 0) begin errors++; $display("FAIL nongpio_lo got %0d exp 0", n); end
  endtask
  task automatic test_rst_after_store();
    logic [31:0] p [$];
    int k = 0;
    p = '{32'h00010137, 32'h01D00513, 32'h00A10223, 32'h0000006F};
    load(p);
    @(negedge clk_i);
    rst_i = 0;
    while (cs_o !== 1'b1 && k < 40) begin @(negedge clk_i); k++; end
    checks++; if (cs_o !== 1'b1) begin errors++; $display("FAIL rst_store_seen got %h exp 1", cs_o); end
    rst_i = 1;
    @(negedge clk_i);
    checks++; if (cs_o !== 1'b0) begin errors++; $display("FAIL rst_store_cs got %h exp 0", cs_o); end
    checks++; if (dut.pc !== 64'h0) begin errors++; $display("FAIL rst_store_pc got %h exp 0", dut.pc); end
    checks++; if (gpio_o !== 32'h0) begin errors++; $display("FAIL rst_store_gpio got %h exp 0", gpio_o); end
  endtask
  task automatic test_trst_mid_shift();
    logic b;
    logic [42:0] g, e;
    logic [42:0] din = {11'($urandom), $urandom};
    logic [7:0] o;
    tclk(1'b1, 1'b0, b); tclk(1'b0, 1'b0, b); tclk(1'b0, 1'b0, b);
    for (int i = 0; i < 20; i++) tclk(1'b0, 1'($urandom), b);
    trst_i = 1;
    repeat (3) @(negedge clk_i);
    trst_i = 0;
    dr_m = '0;
    checks++; if (tdo_o !== 1'b0) begin errors++; $display("FAIL trst_tdo got %h exp 0", tdo_o); end
    checks++; if (dut.u_tap.ir !== 8'h00) begin errors++; $display("FAIL trst_ir got %h exp 00", dut.u_tap.ir); end
    tclk(1'b0, 1'b0, b);
    scan_dr(din, g);
    checks++; if (g !== {1'b0, din[42:1]}) begin errors++; $display("FAIL trst_bypass got %h exp %h", g, {1'b0, din[42:1]}); end
    shift_ir(8'h80, o);
    imdr(10'h100, 32'h0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL trst_cap0 got %h exp %h", g, e); end
    imdr(10'h100, 32'h0, 1'b0, g, e);
    checks++; if (g !== e) begin errors++; $display("FAIL trst_nowrite got %h exp %h", g, e); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 'x;
    test_reset();
    test_ir();
    test_imdr_rw();
    test_we0();
    test_program();
    test_branch_nop();
    test_jal_beq();
    test_random_store();
    test_non_gpio();
    test_rst_after_store();
    test_trst_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #4000000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/as_top_mem.md
AS_TOP_MEM -- requirements
Module: as_top_mem

Interface
REQ-001 SHALL have parameter IMEM_ADDR_W, default 10, byte-address width of instruction memory (256 words).
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter NR_GPIOS, default 32, gpio_o width.
REQ-004 SHALL have parameter GPIO_ADDR_W, default 8, gpioAddr_o width.
REQ-005 SHALL have parameter IR_W, default 8, JTAG instruction register width; IMDR opcode 0x80.
REQ-006 SHALL have port clk_i, input, 1, sole clock; all flops on rising edge.
REQ-007 SHALL have port rst_i, input, 1, core reset, synchronous, active-high; holds core while I-Mem loads.
REQ-008 SHALL have port tck_i, input, 1, JTAG clock, sampled in the clk_i domain, ≤ clk_i/4.
REQ-009 SHALL have ports trst_i (synchronous active-high TAP reset), tms_i, tdi_i, each input, 1.
REQ-010 SHALL have port tdo_o, output, 1, MSB of the selected shift register.
REQ-011 SHALL have ports gpio_o output NR_GPIOS, gpioAddr_o output GPIO_ADDR_W, cs_o output 1 (GPIO write strobe).

Function
REQ-012 SHALL synchronise tck_i through 2 flops and derive one-cycle rise/fall pulses; TAP actions occur only on these pulses.
REQ-013 SHALL implement the 16-state IEEE 1149.1 TAP FSM advancing on tck rise using tms_i; 5 rises with tms_i=1 reach Test-Logic-Reset from any state.
REQ-014 Capture-IR SHALL load 0x01; Shift-IR SHALL shift left with tdi_i entering LSB; Update-IR SHALL copy to IR; Test-Logic-Reset SHALL set IR=0x00 (BYPASS).
REQ-015 With IR=0x80, DR SHALL be the 43-bit IMDR {addr[9:0], data[31:0], we}; first bit shifted in lands in MSB after 43 shifts.
REQ-016 Capture-DR (IMDR) SHALL load {addr, imem[addr[9:2]], 0}; Update-DR with we=1 SHALL write imem[addr[9:2]]=data in one clk; we=0 writes nothing.
REQ-017 Any other IR value SHALL select a 1-bit bypass register.
REQ-018 tdo_o SHALL update only on tck fall pulses.
REQ-019 Core SHALL be single-cycle RV64I subset: one instruction per clk_i while rst_i=0; PC 64-bit; fetch combinational from imem[pc[9:2]].
REQ-020 Supported: LUI, ADDI, JAL, BEQ, BNE, SB/SH/SW/SD; any other encoding executes as NOP (PC+4).
REQ-021 Register file 32x64, x0 reads zero; LUI/ADDI results sign-extended to 64 bits, wrap modulo 2^64.
REQ-022 Branch/jump targets = PC + sign-extended imm; JAL writes PC+4 to rd (unless rd=x0).
REQ-023 Store address = rs1 + sext(imm); if addr[63:16]==0x1 (GPIO region) the cycle after the store SHALL drive cs_o=1, gpioAddr_o=addr[7:0], gpio_o=rs2 zero-extended from the store size, for exactly one cycle.
REQ-024 Stores outside the GPIO region SHALL be ignored (no data memory); cs_o=0 in all non-GPIO-store cycles; gpio_o/gpioAddr_o hold last value.
REQ-025 IMDR writes SHALL be accepted regardless of rst_i; a write to the word being fetched while running SHALL take effect from the next fetch.

Reset
REQ-026 rst_i=1 SHALL set PC=0, all registers=0, cs_o=0, gpio_o=0, gpioAddr_o=0 at the next clk_i edge; imem contents unaffected.
REQ-027 trst_i=1 SHALL force TAP to Test-Logic-Reset, IR=0x00, shift registers=0, tdo_o=0; core unaffected.
REQ-028 rst_i asserted mid-execution SHALL abort any pending cs_o pulse.

Structure
REQ-029 Package as_pack SHALL hold IMEM_ADDR_W, INSTR_W, IM_SCAN_LEN=43, NR_GPIOS, GPIO_ADDR_W, IR_W, IMDR opcode, GPIO base, RV opcode constants and the TAP state enum.
REQ-030 One sub-module as_jtag_tap (sync, FSM, IR, IMDR/bypass, write strobe) SHALL be instantiated; core and imem stay in as_top_mem.

Verification
REQ-031 tms_i=1 for 5 tck, then RTI->IR path shifting 0x80 -> IR=0x80 after Update-IR.
REQ-032 IMDR scans addr 0x000..0x010 data 0, we=1; then 0x00010137, 0x01D00513, 0x00A10223, 0x0000006F at 0x0,0x4,0x8,0xC; release rst_i -> cs_o=1, gpioAddr_o=0x04, gpio_o=29 once.
REQ-033 IMDR scan with we=0 -> imem unchanged; following Capture-DR shifts out previously written data on tdo_o.
REQ-034 trst_i=1 mid Shift-DR -> TAP in Test-Logic-Reset, IR=0x00, no imem write.
REQ-035 Program with BNE x0,x0 and an undefined opcode -> both behave as PC+4, no cs_o.
REQ-036 rst_i=1 in the cycle after a GPIO store -> cs_o=0, PC=0 next cycle.
